clause_array_ls_vs_list: RTL and testbench
==========================================

Name: clause_array_ls_vs_list

Overview:
- Per-bin state store for the SAT engine. It holds three things for one bin:
  - a clause array of NUM_CLAUSES clauses over NUM_VARS literal slots;
  - a variable-state list (value, implied flag, decision level per variable);
  - a level-state list (decided bin id, backtrack flag per level).
- Load/readback ports match the engine's bin load/unload interface.
- It computes clause-satisfaction status from the stored clauses and current variable values.

Parameters:
- NUM_CLAUSES, 8, number of clause rows.
- NUM_VARS, 8, number of variable slots (literal columns).
- NUM_LVLS, 8, number of level-state entries.
- WIDTH_BIN_ID, 15, bin-id field width in a level state.
- WIDTH_LVL, 16, level field width in a variable state.
- WIDTH_VAR_STATES, 19, variable-state width; must equal 2+1+WIDTH_LVL.
- WIDTH_LVL_STATES, 16, level-state width; must equal WIDTH_BIN_ID+1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- wr_carray_i  in  NUM_CLAUSES  one-hot clause write select.
- clause_i  in  NUM_VARS*2  clause write data.
- rd_carray_i  in  NUM_CLAUSES  one-hot clause read select.
- clause_o  out  NUM_VARS*2  registered clause read data.
- wr_var_states  in  NUM_VARS  per-variable write enable.
- vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS  variable-state write data.
- vars_states_o  out  WIDTH_VAR_STATES*NUM_VARS  stored variable states.
- wr_lvl_states  in  NUM_LVLS  per-level write enable.
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS  level-state write data.
- lvl_states_o  out  WIDTH_LVL_STATES*NUM_LVLS  stored level states.
- c_is_sat_o  out  NUM_CLAUSES  per-clause satisfied flag.
- all_c_is_sat_o  out  1  AND of c_is_sat_o.

Behaviour:
- Encodings:
  - 2-bit literal, clause bits [2j+1:2j] for variable j: 00 absent, 01 positive, 10 negative, 11 treated as absent.
  - Variable state j occupies bits [19j+18:19j]. Value [18:17] is 00 free, 01 true, 10 false, 11 treated as free. Implied is [16]. Level is [15:0].
  - Level state k occupies bits [16k+15:16k]. dcd_bin is [15:1]; has_bkt is [0].
- Reset (rst=0, asynchronous): all clause rows, variable states, level states and clause_o are cleared to 0. c_is_sat_o is then all-ones (empty clauses) and all_c_is_sat_o is 1.
- Clause write: at a rising edge, every row i with wr_carray_i[i]=1 loads clause_i. If several bits are set, all selected rows get the same data. Rows not selected hold.
- Clause read:
  - clause_o <= OR of the rows selected by rd_carray_i, one cycle after rd_carray_i is sampled.
  - rd_carray_i=0 gives clause_o <= 0.
  - Reading a row in the same cycle it is written returns the old contents; the new data is visible on the next read.
- Variable states: at an edge, slot j loads its field of vars_states_i when wr_var_states[j]=1, otherwise holds. vars_states_o is the register contents, combinational from the registers and visible the cycle after the write.
- Level states: same rule as variable states, using wr_lvl_states and lvl_states_i; lvl_states_o is the register contents.
- Satisfaction, combinational from the stored registers:
  - A literal in row i, column j is true when the literal is 01 or 10 and equals the value field of variable j.
  - c_is_sat_o[i] = row has no valid literal, OR any of its literals is true.
  - all_c_is_sat_o = &c_is_sat_o.
- Simultaneous events: clause, variable and level writes and a clause read may all occur in one cycle and are independent. Updated satisfaction flags appear the cycle after the write edge.
- Reset asserted mid-operation clears all state immediately, regardless of pending write enables.

Test Plan:
- Reset, then read rows 0..7 one per cycle -> clause_o=0 each cycle, all_c_is_sat_o=1, vars_states_o=0, lvl_states_o=0.
- Write row 0 = 16'h0005 (x0 positive, x1 positive) and row 1 = 16'h000A (x0 negative, x1 negative), then read rows 0,1 -> clause_o 16'h0005 then 16'h000A, each one cycle after its select.
- Vars write, wr_var_states=8'hFF, value of x0=01 with level 1 implied 0, value of x1=10 with level 2 implied 1, others 0 -> vars_states_o bits[18:0]=19'h20001, bits[37:19]=19'h50002; rows 0 and 1 both sat; all_c_is_sat_o=1.
- Rewrite only x1 to value 01 (wr_var_states=8'h02) -> x0 unchanged; row 1 unsat (x0 true, x1 true against negative literals); all_c_is_sat_o=0 the next cycle.
- Levels write, dcd_bin={1,2,0,...}, has_bkt={0,1,0,...}, wr_lvl_states=8'hFF -> lvl_states_o[15:0]=16'h0002, [31:16]=16'h0005; a later write with wr_lvl_states=8'h00 leaves it unchanged.
- Write row 2 in the same cycle it is read -> clause_o shows the old value; a read next cycle shows the new value. rst pulsed low mid-sequence -> all outputs return to their reset values at once.

Source files
------------

// File: rtl/clause_array_ls_vs_list.sv
// Per-bin SAT state store: clause array, variable-state list and level-state list,
// with combinational clause-satisfaction status derived from the stored contents.
module clause_array_ls_vs_list #(
  parameter int unsigned NUM_CLAUSES      = 8,
  parameter int unsigned NUM_VARS         = 8,
  parameter int unsigned NUM_LVLS         = 8,
  parameter int unsigned WIDTH_BIN_ID     = 15,
  parameter int unsigned WIDTH_LVL        = 16,
  parameter int unsigned WIDTH_VAR_STATES = 19,
  parameter int unsigned WIDTH_LVL_STATES = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CLAUSES-1:0]               wr_carray_i,
  input  logic [NUM_VARS*2-1:0]                clause_i,
  input  logic [NUM_CLAUSES-1:0]               rd_carray_i,
  output logic [NUM_VARS*2-1:0]                clause_o,
  input  logic [NUM_VARS-1:0]                  wr_var_states,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
  input  logic [NUM_LVLS-1:0]                  wr_lvl_states,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
  output logic [NUM_CLAUSES-1:0]               c_is_sat_o,
  output logic                                 all_c_is_sat_o
);

  localparam int unsigned ClauseW = NUM_VARS * 2;
  localparam int unsigned VarsW   = WIDTH_VAR_STATES * NUM_VARS;
  localparam int unsigned LvlsW   = WIDTH_LVL_STATES * NUM_LVLS;

  logic [ClauseW-1:0] clause_q [NUM_CLAUSES];
  logic [ClauseW-1:0] clause_d [NUM_CLAUSES];
  logic [ClauseW-1:0] rd_data_q, rd_data_d;
  logic [VarsW-1:0]   vars_q, vars_d;
  logic [LvlsW-1:0]   lvls_q, lvls_d;

  // Clause rows: every selected row takes the same write data.
  always_comb begin
    for (int i = 0; i < NUM_CLAUSES; i++) begin
      clause_d[i] = clause_q[i];
      if (wr_carray_i[i]) begin
        clause_d[i] = clause_i;
      end
    end
  end

  // Read returns the pre-write contents since it is built from clause_q.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CLAUSES; i++) begin
      if (rd_carray_i[i]) begin
        rd_data_d = rd_data_d | clause_q[i];
      end
    end
  end

  always_comb begin
    vars_d = vars_q;
    for (int j = 0; j < NUM_VARS; j++) begin
      if (wr_var_states[j]) begin
        vars_d[WIDTH_VAR_STATES*j +: WIDTH_VAR_STATES] =
          vars_states_i[WIDTH_VAR_STATES*j +: WIDTH_VAR_STATES];
      end
    end
  end

  always_comb begin
    lvls_d = lvls_q;
    for (int k = 0; k < NUM_LVLS; k++) begin
      if (wr_lvl_states[k]) begin
        lvls_d[WIDTH_LVL_STATES*k +: WIDTH_LVL_STATES] =
          lvl_states_i[WIDTH_LVL_STATES*k +: WIDTH_LVL_STATES];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLAUSES; i++) begin
        clause_q[i] <= '0;
      end
      rd_data_q <= '0;
      vars_q    <= '0;
      lvls_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CLAUSES; i++) begin
        clause_q[i] <= clause_d[i];
      end
      rd_data_q <= rd_data_d;
      vars_q    <= vars_d;
      lvls_q    <= lvls_d;
    end
  end

  // A literal counts only when it is 01/10; it is true when it matches the variable value.
  always_comb begin
    logic [1:0] lit;
    logic [1:0] val;
    logic       has_lit;
    logic       lit_true;
    lit        = '0;
    val        = '0;
    c_is_sat_o = '0;
    for (int i = 0; i < NUM_CLAUSES; i++) begin
      has_lit  = 1'b0;
      lit_true = 1'b0;
      for (int j = 0; j < NUM_VARS; j++) begin
        lit = clause_q[i][2*j +: 2];
        val = vars_q[WIDTH_VAR_STATES*j + WIDTH_VAR_STATES - 2 +: 2];
        if (lit == 2'b01 || lit == 2'b10) begin
          has_lit = 1'b1;
          if (lit == val) begin
            lit_true = 1'b1;
          end
        end
      end
      c_is_sat_o[i] = !has_lit || lit_true;
    end
  end

  assign all_c_is_sat_o = &c_is_sat_o;
  assign clause_o       = rd_data_q;
  assign vars_states_o  = vars_q;
  assign lvl_states_o   = lvls_q;

endmodule

// File: tb/tb_clause_array_ls_vs_list.sv
// Randomized scoreboard bench for clause_array_ls_vs_list against a field-level model.
module tb_clause_array_ls_vs_list;

  logic         clk;
  logic         rst;
  logic [7:0]   wr_carray_i;
  logic [15:0]  clause_i;
  logic [7:0]   rd_carray_i;
  logic [15:0]  clause_o;
  logic [7:0]   wr_var_states;
  logic [151:0] vars_states_i;
  logic [151:0] vars_states_o;
  logic [7:0]   wr_lvl_states;
  logic [127:0] lvl_states_i;
  logic [127:0] lvl_states_o;
  logic [7:0]   c_is_sat_o;
  logic         all_c_is_sat_o;

  clause_array_ls_vs_list dut (
    .clk            (clk),
    .rst            (rst),
    .wr_carray_i    (wr_carray_i),
    .clause_i       (clause_i),
    .rd_carray_i    (rd_carray_i),
    .clause_o       (clause_o),
    .wr_var_states  (wr_var_states),
    .vars_states_i  (vars_states_i),
    .vars_states_o  (vars_states_o),
    .wr_lvl_states  (wr_lvl_states),
    .lvl_states_i   (lvl_states_i),
    .lvl_states_o   (lvl_states_o),
    .c_is_sat_o     (c_is_sat_o),
    .all_c_is_sat_o (all_c_is_sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: rows, variable fields and level fields as plain arrays.
  logic [15:0] m_clause [8];
  logic [1:0]  m_val    [8];
  logic        m_imp    [8];
  logic [15:0] m_lvl    [8];
  logic [14:0] m_bin    [8];
  logic        m_bkt    [8];
  logic [15:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_clause[i] = '0; m_val[i] = '0; m_imp[i] = 1'b0; m_lvl[i] = '0;
      m_bin[i] = '0; m_bkt[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  function automatic logic [151:0] model_vars();
    logic [151:0] v = '0;
    for (int j = 0; j < 8; j++) v[19*j +: 19] = {m_val[j], m_imp[j], m_lvl[j]};
    return v;
  endfunction

  function automatic logic [127:0] model_lvls();
    logic [127:0] v = '0;
    for (int k = 0; k < 8; k++) v[16*k +: 16] = {m_bin[k], m_bkt[k]};
    return v;
  endfunction

  // Clause satisfied if it has no 01/10 literal or some literal agrees with its variable value.
  function automatic logic [7:0] model_sat();
    logic [7:0] s;
    for (int i = 0; i < 8; i++) begin
      int n_lits = 0;
      int n_true = 0;
      for (int j = 0; j < 8; j++) begin
        int lit = int'(m_clause[i][2*j +: 2]);
        if (lit == 1 || lit == 2) begin
          n_lits++;
          if (lit == int'(m_val[j])) n_true++;
        end
      end
      s[i] = (n_lits == 0) || (n_true > 0);
    end
    return s;
  endfunction

  // One clock: drive, let the edge happen, then advance the model as the hardware should.
  task automatic step(input logic [7:0] wc, input logic [15:0] cd, input logic [7:0] rc,
                      input logic [7:0] wv, input logic [151:0] vd,
                      input logic [7:0] wl, input logic [127:0] ld);
    logic [15:0] rd_exp;
    wr_carray_i = wc; clause_i = cd; rd_carray_i = rc;
    wr_var_states = wv; vars_states_i = vd; wr_lvl_states = wl; lvl_states_i = ld;
    @(posedge clk);
    rd_exp = '0;
    for (int i = 0; i < 8; i++) if (rc[i]) rd_exp = rd_exp | m_clause[i];
    exp_q.push_back(rd_exp);
    for (int i = 0; i < 8; i++) if (wc[i]) m_clause[i] = cd;
    for (int j = 0; j < 8; j++) if (wv[j]) {m_val[j], m_imp[j], m_lvl[j]} = vd[19*j +: 19];
    for (int k = 0; k < 8; k++) if (wl[k]) {m_bin[k], m_bkt[k]} = ld[16*k +: 16];
    #1;
  endtask

  task automatic idle();
    step(8'h0, 16'h0, 8'h0, 8'h0, '0, 8'h0, '0);
  endtask

  // Monitor: compares every registered/combinational output against the model each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("clause_o", {136'b0, clause_o}, {136'b0, exp_q.pop_front()});
    chk("vars_states_o", vars_states_o, model_vars());
    chk("lvl_states_o", {24'b0, lvl_states_o}, {24'b0, model_lvls()});
    chk("c_is_sat_o", {144'b0, c_is_sat_o}, {144'b0, model_sat()});
    chk("all_c_is_sat_o", {151'b0, all_c_is_sat_o}, {151'b0, &model_sat()});
  end

  logic [151:0] vd;
  logic [127:0] ld;
  logic [15:0]  cd;
  logic [7:0]   wc, rc;

  initial begin
    model_clear();
    rst = 1'b0;
    wr_carray_i = '0; clause_i = '0; rd_carray_i = '0;
    wr_var_states = '0; vars_states_i = '0; wr_lvl_states = '0; lvl_states_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;

    // Read every row after reset.
    for (int i = 0; i < 8; i++) begin
      rc = 8'h1 << i;
      step(8'h0, 16'h0, rc, 8'h0, '0, 8'h0, '0);
      chk("reset_read", {136'b0, clause_o}, 152'h0);
    end
    chk("reset_all_sat", {151'b0, all_c_is_sat_o}, 152'h1);

    step(8'h01, 16'h0005, 8'h0, 8'h0, '0, 8'h0, '0);
    step(8'h02, 16'h000A, 8'h0, 8'h0, '0, 8'h0, '0);
    step(8'h0, 16'h0, 8'h01, 8'h0, '0, 8'h0, '0);
    chk("read_row0", {136'b0, clause_o}, {136'b0, 16'h0005});
    step(8'h0, 16'h0, 8'h02, 8'h0, '0, 8'h0, '0);
    chk("read_row1", {136'b0, clause_o}, {136'b0, 16'h000A});

    vd = '0;
    vd[18:0]  = {2'b01, 1'b0, 16'd1};
    vd[37:19] = {2'b10, 1'b1, 16'd2};
    step(8'h0, 16'h0, 8'h0, 8'hFF, vd, 8'h0, '0);
    chk("vars_x0", {133'b0, vars_states_o[18:0]}, {133'b0, 19'h20001});
    chk("vars_x1", {133'b0, vars_states_o[37:19]}, {133'b0, 19'h50002});
    chk("sat_rows01", {150'b0, c_is_sat_o[1:0]}, {150'b0, 2'b11});
    chk("all_sat_1", {151'b0, all_c_is_sat_o}, 152'h1);

    vd = '0;
    vd[37:19] = {2'b01, 1'b1, 16'd2};
    step(8'h0, 16'h0, 8'h0, 8'h02, vd, 8'h0, '0);
    chk("vars_x0_hold", {133'b0, vars_states_o[18:0]}, {133'b0, 19'h20001});
    chk("row1_unsat", {151'b0, c_is_sat_o[1]}, 152'h0);
    chk("all_sat_0", {151'b0, all_c_is_sat_o}, 152'h0);

    ld = '0;
    ld[15:0]  = {15'd1, 1'b0};
    ld[31:16] = {15'd2, 1'b1};
    step(8'h0, 16'h0, 8'h0, 8'h0, '0, 8'hFF, ld);
    chk("lvl0", {136'b0, lvl_states_o[15:0]}, {136'b0, 16'h0002});
    chk("lvl1", {136'b0, lvl_states_o[31:16]}, {136'b0, 16'h0005});
    step(8'h0, 16'h0, 8'h0, 8'h0, '0, 8'h00, ~ld);
    chk("lvl_hold", {136'b0, lvl_states_o[31:0]}, {136'b0, 32'h0005_0002});

    // Same-cycle write and read of row 2 returns the old row.
    step(8'h04, 16'h0041, 8'h04, 8'h0, '0, 8'h0, '0);
    chk("rw_same_old", {136'b0, clause_o}, 152'h0);
    step(8'h0, 16'h0, 8'h04, 8'h0, '0, 8'h0, '0);
    chk("rw_next_new", {136'b0, clause_o}, {136'b0, 16'h0041});
    step(8'h0, 16'h0, 8'h07, 8'h0, '0, 8'h0, '0);
    chk("read_multi_or", {136'b0, clause_o}, {136'b0, 16'h004F});

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cd = '0;
      for (int j = 0; j < 8; j++) if ($urandom_range(0, 2) == 0) cd[2*j +: 2] = 2'($urandom);
      case ($urandom_range(0, 3))
        0: wc = 8'h0;
        1, 2: wc = 8'h1 << $urandom_range(0, 7);
        default: wc = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rc = 8'h0;
        1, 2: rc = 8'h1 << $urandom_range(0, 7);
        default: rc = 8'($urandom);
      endcase
      for (int w = 0; w < 5; w++) vd[32*w +: 32] = $urandom;
      for (int w = 0; w < 4; w++) ld[32*w +: 32] = $urandom;
      step(wc, cd, rc, 8'($urandom) & 8'($urandom), vd, 8'($urandom), ld);

      // Asynchronous reset mid-stream, with writes still pending on the inputs.
      if (n == 200) begin
        wr_carray_i = 8'hFF; wr_var_states = 8'hFF; wr_lvl_states = 8'hFF;
        #2 rst = 1'b0;
        #1;
        chk("rst_clause_o", {136'b0, clause_o}, 152'h0);
        chk("rst_vars", vars_states_o, 152'h0);
        chk("rst_lvls", {24'b0, lvl_states_o}, 152'h0);
        chk("rst_sat", {144'b0, c_is_sat_o, all_c_is_sat_o}, {143'b0, 9'h1FF});
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end

    idle();
    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
